// File: rtl/mips_memory.sv
// ---------------------------------------------------------------------------
// mips_memory
//
// This is the unified instruction and data memory for the multicycle MIPS core.
// It also holds a boot loader and a memory-mapped output register.
//
// Operation:
//   - After reset the block is in LOAD. A byte-stream loader fills the RAM
//     from address 0 upward.
//   - The stream ends in one of two ways:
//       * a byte flagged with load_last is accepted, or
//       * the RAM fills.
//     Either way, the block moves to RUN and raises cpu_run. cpu_run drives
//     the core's reset input.
//   - In RUN the core reads the RAM combinationally and writes it on the
//     clock edge.
//   - Address IO_ADDR is decoded as the output register io_out. Each core
//     write to it pulses io_strobe for one cycle.
//   - The RAM contents survive reset. A fresh load overlays them.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   memread     core read strobe (intent only, no side effect)
//   memwrite    core write strobe
//   adr         core address                  [WIDTH]
//   writedata   core write data               [WIDTH]
//   memdata     combinational read data       [WIDTH]
//   load_valid  loader byte valid
//   load_data   loader byte                   [WIDTH]
//   load_last   marks the final loader byte
//   load_ready  block accepts a loader byte (LOAD state, out of reset)
//   load_sum    running sum of accepted loader bytes, mod 2^WIDTH
//   cpu_run     high once loading is complete; held until reset
//   io_out      memory-mapped output register
//   io_strobe   one-cycle pulse after each core write to IO_ADDR
// ---------------------------------------------------------------------------
module mips_memory #(
  parameter int unsigned          WIDTH    = 8,
  parameter int unsigned          ADDRBITS = 8,
  parameter logic [WIDTH-1:0]     IO_ADDR  = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic [WIDTH-1:0] load_sum,
  output logic             cpu_run,
  output logic [WIDTH-1:0] io_out,
  output logic             io_strobe
);

  localparam int unsigned DEPTH = 1 << ADDRBITS;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // State and registers
  // -------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [ADDRBITS-1:0] ptr_q,      ptr_d;
  logic [WIDTH-1:0]    load_sum_q, load_sum_d;
  logic [WIDTH-1:0]    io_out_q,   io_out_d;
  logic                io_strobe_q, io_strobe_d;

  logic [WIDTH-1:0]    mem [DEPTH];

  logic                load_fire;
  logic                core_io_we;
  logic                core_ram_we;
  logic                mem_we;
  logic [ADDRBITS-1:0] mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [ADDRBITS-1:0] core_idx;
  logic                is_io_adr;

  // memread only signals the core's intent. The read path is always active,
  // so memread has no effect on this block.
  logic unused_memread;
  assign unused_memread = memread;

  assign core_idx  = adr[ADDRBITS-1:0];
  assign is_io_adr = (adr == IO_ADDR);

  // load_ready is gated with rst so it reads 0 for the whole time reset is
  // held, even though the state register already sits in LOAD.
  assign load_ready = rst && (state_q == ST_LOAD);
  assign load_fire  = load_valid && load_ready;

  // The core writes only in RUN. Strobes issued during LOAD are dropped.
  assign core_io_we  = (state_q == ST_RUN) && memwrite &&  is_io_adr;
  assign core_ram_we = (state_q == ST_RUN) && memwrite && !is_io_adr;

  // -------------------------------------------------------------------------
  // Next-state and register updates
  // -------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_sum_d  = load_sum_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          ptr_d      = ptr_q + 1'b1;
          load_sum_d = load_sum_q + load_data;
          // The last slot ends the load whether or not load_last is set.
          // This keeps the pointer from wrapping into a second pass.
          if (load_last || (&ptr_q)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (core_io_we) begin
          io_out_d    = writedata;
          io_strobe_d = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      ptr_q       <= '0;
      load_sum_q  <= '0;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_sum_q  <= load_sum_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
    end
  end

  // -------------------------------------------------------------------------
  // RAM write port
  // -------------------------------------------------------------------------
  // The loader and the core never compete for this port: the loader writes
  // only in LOAD and the core writes only in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = load_data;
    if (load_fire) begin
      mem_we = 1'b1;
    end else if (core_ram_we) begin
      mem_we    = 1'b1;
      mem_waddr = core_idx;
      mem_wdata = writedata;
    end
  end

  // NOTE: the RAM array has no reset. Its contents are meant to survive rst,
  // and leaving the reset off lets it map onto a plain memory macro.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Combinational read path
  // -------------------------------------------------------------------------
  // The core latches IR/MDR at the end of the strobe cycle, so data has to be
  // valid in the same cycle as adr. A write on this edge shows up from the
  // next cycle onward.
  always_comb begin
    memdata = '0;
    if (state_q == ST_RUN) begin
      memdata = is_io_adr ? io_out_q : mem[core_idx];
    end
  end

  assign load_sum  = load_sum_q;
  assign cpu_run   = (state_q == ST_RUN);
  assign io_out    = io_out_q;
  assign io_strobe = io_strobe_q;

endmodule
